// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_add_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;

   modport master (
      output Start, A, B, Cin,
      input  Busy, Done, Sum, Cout
   );

   modport slave (
      input  Start, A, B, Cin,
      output Busy, Done, Sum, Cout
   );

endinterface

// File: rtl/serial_add_fulladd.sv
// One-bit adder cells: a half adder and a full adder built from two of them.
module HalfAdd (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);

   // Sum and carry of two bits.
   assign sum  = a ^ b;
   assign cout = a & b;

endmodule

module FullAdd (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s1;
   logic c1;
   logic c2;

   HalfAdd ha_ab (
      .a    (a),
      .b    (b),
      .sum  (s1),
      .cout (c1)
   );

   HalfAdd ha_cin (
      .a    (s1),
      .b    (cin),
      .sum  (sum),
      .cout (c2)
   );

   // At most one half adder can generate a carry, so OR combines them.
   assign cout = c1 | c2;

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: one full-adder bit per cycle, LSB first, result posted after WIDTH cycles.
module serial_add
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic        Clk,
   input  logic        Reset,
   serial_add_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [WIDTH-1:0] part;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             busy_r;
   logic             done_r;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] part_next;

   FullAdd u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
   assign part_next = (part >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

   // Control FSM plus datapath registers; results only update on the final shift edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         carry  <= 1'b0;
         part   <= '0;
         cnt    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  a_sh   <= bus.A;
                  b_sh   <= bus.B;
                  carry  <= bus.Cin;
                  part   <= '0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= fa_cout;
               part  <= part_next;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sum_r  <= part_next;
                  cout_r <= fa_cout;
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.Busy = busy_r;
   assign bus.Done = done_r;
   assign bus.Sum  = sum_r;
   assign bus.Cout = cout_r;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add (WIDTH=8): vector table plus multi-cycle corner cases.
module tb_serial_add;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] expSum;
      logic       expCout;
   } vec_t;

   logic Clk;
   logic Reset;
   int   checks;
   int   errors;
   logic [7:0] lastSum;

   serial_add_if #(.WIDTH(8)) bus ();

   serial_add #(.WIDTH(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
      end
   endtask

   // One addition with inputs scrambled while in flight; checks latency, hold and result.
   task automatic applyStimulus(input vec_t v, input string tag);
      int n;
      int holdErr;
      bus.Start = 1'b1;
      bus.A     = v.a;
      bus.B     = v.b;
      bus.Cin   = v.cin;
      tick();
      checkOutput({tag, " busy_after_accept"}, 32'(bus.Busy), 32'd1);
      n = 0;
      holdErr = 0;
      while (!bus.Done && n < 20) begin
         if (bus.Sum !== lastSum) holdErr++;
         bus.Start = 1'($urandom);
         bus.A     = 8'($urandom);
         bus.B     = 8'($urandom);
         bus.Cin   = 1'($urandom);
         tick();
         n++;
      end
      bus.Start = 1'b0;
      checkOutput({tag, " latency"}, 32'(n), 32'd8);
      checkOutput({tag, " sum_hold"}, 32'(holdErr), 32'd0);
      checkOutput({tag, " sum"}, 32'(bus.Sum), 32'(v.expSum));
      checkOutput({tag, " cout"}, 32'(bus.Cout), 32'(v.expCout));
      checkOutput({tag, " busy_in_done"}, 32'(bus.Busy), 32'd1);
      lastSum = v.expSum;
      tick();
      checkOutput({tag, " done_one_cycle"}, 32'(bus.Done), 32'd0);
      checkOutput({tag, " idle_busy"}, 32'(bus.Busy), 32'd0);
   endtask

   vec_t vecs[8];

   initial begin
      int doneCnt;
      int firstDone;
      int secondDone;
      int busyLow;
      int sumBad;
      int sawDone;

      checks  = 0;
      errors  = 0;
      lastSum = 8'h00;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
      vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
      vecs[6] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
      vecs[7] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};

      Reset     = 1'b1;
      bus.Start = 1'b1;
      bus.A     = 8'hAA;
      bus.B     = 8'h55;
      bus.Cin   = 1'b1;
      tick();
      tick();
      checkOutput("reset busy", 32'(bus.Busy), 32'd0);
      checkOutput("reset done", 32'(bus.Done), 32'd0);
      checkOutput("reset sum", 32'(bus.Sum), 32'd0);
      checkOutput("reset cout", 32'(bus.Cout), 32'd0);
      bus.Start = 1'b0;
      Reset     = 1'b0;
      tick();
      tick();
      checkOutput("idle hold busy", 32'(bus.Busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Start held high: back-to-back additions every WIDTH+2 cycles.
      bus.A     = 8'h03;
      bus.B     = 8'h04;
      bus.Cin   = 1'b0;
      bus.Start = 1'b1;
      doneCnt = 0;
      firstDone = -1;
      secondDone = -1;
      busyLow = 0;
      sumBad = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (!bus.Busy) busyLow++;
         if (bus.Done) begin
            doneCnt++;
            if (bus.Sum !== 8'h07) sumBad++;
            if (firstDone < 0) firstDone = c;
            else if (secondDone < 0) secondDone = c;
         end
      end
      bus.Start = 1'b0;
      checkOutput("held_start done_count", 32'(doneCnt), 32'd2);
      checkOutput("held_start first_done", 32'(firstDone), 32'd9);
      checkOutput("held_start spacing", 32'(secondDone - firstDone), 32'd10);
      checkOutput("held_start sum_bad", 32'(sumBad), 32'd0);
      checkOutput("held_start busy_low", 32'(busyLow), 32'd2);
      lastSum = 8'h07;
      tick();

      // Reset in the middle of a shift aborts the operation.
      bus.A     = 8'h0F;
      bus.B     = 8'h01;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick();
      tick();
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checkOutput("abort busy", 32'(bus.Busy), 32'd0);
      checkOutput("abort sum", 32'(bus.Sum), 32'd0);
      checkOutput("abort cout", 32'(bus.Cout), 32'd0);
      sawDone = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus.Done) sawDone++;
      end
      checkOutput("abort no_done", 32'(sawDone), 32'd0);
      lastSum = 8'h00;

      // Start in the very first cycle after reset releases is accepted.
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      applyStimulus('{8'h21, 8'h01, 1'b0, 8'h22, 1'b0}, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
